ip_codma_ap_ctrl: RTL and testbench

- Controller for the codma address-phase FIFO.
- Arbitrates round-robin between the read engine and the write engine, and pushes the winning request into the FIFO.
- Sequences the data phase of the head entry and issues the single-cycle pop (fifo_rd_next) when that data phase completes.
- Sits between the two DMA engines and the AP FIFO / bus data-phase logic.

---
 rtl/ip_codma_fifo_pkg.sv | 22 ++
 rtl/ip_codma_machine_states_pkg.sv | 20 ++
 rtl/ip_codma_ap_ctrl_rr_arb2.sv | 60 ++++++
 rtl/ip_codma_ap_ctrl.sv | 143 ++++++++++++++
 tb/tb_ip_codma_ap_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ip_codma_fifo_pkg.sv
// ----------------------------------------------------------------------------
// ip_codma_fifo_pkg
// Shared definitions for the codma address-phase (AP) FIFO.
//   NO_OF_AF_BUFFERS : depth of the AP FIFO; the controller stops granting at
//                      this occupancy.
//   AP_ADDR_W/SIZE_W : default widths of an AP entry.
//   ap_entry_t       : one AP FIFO entry (direction flags, address, size).
// ----------------------------------------------------------------------------
package ip_codma_fifo_pkg;

  localparam int NO_OF_AF_BUFFERS = 4;
  localparam int AP_ADDR_W        = 32;
  localparam int AP_SIZE_W        = 3;

  typedef struct packed {
    logic                 read;
    logic                 write;
    logic [AP_ADDR_W-1:0] addr;
    logic [AP_SIZE_W-1:0] size;
  } ap_entry_t;

endpackage

// File: rtl/ip_codma_machine_states_pkg.sv
// ----------------------------------------------------------------------------
// ip_codma_machine_states_pkg
// State and grant encodings used by the codma AP controller.
//   ap_ctrl_state_t : data-phase sequencer states (IDLE, ACTIVE, POP).
//   grant_t         : identity of the last arbitration winner (READ, WRITE).
// ----------------------------------------------------------------------------
package ip_codma_machine_states_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    POP    = 2'd2
  } ap_ctrl_state_t;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } grant_t;

endpackage

// File: rtl/ip_codma_ap_ctrl_rr_arb2.sv
// ----------------------------------------------------------------------------
// ip_codma_rr_arb2
// Two-requester round-robin arbiter with a zero-latency grant.
//   clk_i, reset_i  : clock, synchronous active-high reset.
//   en_i            : arbitration enable (FIFO has space, not in reset).
//   req_rd_i        : read engine request.
//   req_wr_i        : write engine request.
//   gnt_rd_o        : read engine granted this cycle.
//   gnt_wr_o        : write engine granted this cycle.
// A lone requester always wins. With both requesting, the one that did not
// win last time is granted. The last winner is only updated when a grant is
// actually issued, so a disabled cycle leaves the rotation untouched.
// ----------------------------------------------------------------------------
module ip_codma_rr_arb2
  import ip_codma_machine_states_pkg::*;
(
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic req_rd_i,
  input  logic req_wr_i,
  output logic gnt_rd_o,
  output logic gnt_wr_o
);

  grant_t last_grant_q;
  grant_t last_grant_d;

  always_comb begin
    gnt_rd_o = 1'b0;
    gnt_wr_o = 1'b0;
    if (en_i) begin
      // Read wins when alone, or when contested and write won last time.
      if (req_rd_i && (!req_wr_i || (last_grant_q == WRITE))) begin
        gnt_rd_o = 1'b1;
      end else if (req_wr_i) begin
        gnt_wr_o = 1'b1;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (gnt_rd_o) begin
      last_grant_d = READ;
    end else if (gnt_wr_o) begin
      last_grant_d = WRITE;
    end
  end

  // Reset to WRITE so the first contested grant goes to the read engine.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      last_grant_q <= WRITE;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/ip_codma_ap_ctrl.sv
// ----------------------------------------------------------------------------
// ip_codma_ap_ctrl
// Controller for the codma address-phase FIFO.
//   clk_i, reset_i           : clock, synchronous active-high reset. reset_i
//                              must also reset the AP FIFO (inverted to its
//                              active-low reset) so occupancy and controller
//                              state agree.
//   rd_req_i/addr/size       : read engine address request (held until gnt).
//   rd_gnt_o                 : read request pushed this cycle.
//   wr_req_i/addr/size       : write engine address request (held until gnt).
//   wr_gnt_o                 : write request pushed this cycle.
//   ap_fifo_count_i          : current FIFO occupancy.
//   ap_read_o/write/addr/size: entry pushed into the FIFO this cycle (zero
//                              when nothing is granted).
//   dp_done_i                : data phase of the head entry finished.
//   fifo_rd_next_o           : one-cycle pop pulse to the FIFO.
//   busy_o                   : sequencer not idle or FIFO not empty.
//   err_o                    : sticky, dp_done_i seen with no active entry.
// ----------------------------------------------------------------------------
module ip_codma_ap_ctrl
  import ip_codma_machine_states_pkg::*;
#(
  parameter int NO_OF_AF_BUFFERS = ip_codma_fifo_pkg::NO_OF_AF_BUFFERS,
  parameter int ADDR_W           = 32,
  parameter int SIZE_W           = 3
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              rd_req_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [SIZE_W-1:0] rd_size_i,
  output logic              rd_gnt_o,
  input  logic              wr_req_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [SIZE_W-1:0] wr_size_i,
  output logic              wr_gnt_o,
  input  logic [2:0]        ap_fifo_count_i,
  output logic              ap_read_o,
  output logic              ap_write_o,
  output logic [ADDR_W-1:0] ap_addr_o,
  output logic [SIZE_W-1:0] ap_size_o,
  input  logic              dp_done_i,
  output logic              fifo_rd_next_o,
  output logic              busy_o,
  output logic              err_o
);

  // Occupancy is a 3-bit count, so the depth must fit in 3 bits (<= 7).
  localparam logic [2:0] AF_DEPTH = 3'(NO_OF_AF_BUFFERS);

  ap_ctrl_state_t state_q, state_d;
  logic           err_q, err_d;
  logic           pop_q, pop_d;

  logic space;
  logic grant;

  // A pop in the same cycle is deliberately not credited as free space.
  // Reset blocks granting so nothing is pushed while the FIFO is being reset.
  assign space = !reset_i && (ap_fifo_count_i < AF_DEPTH);

  ip_codma_rr_arb2 u_arb (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .en_i     (space),
    .req_rd_i (rd_req_i),
    .req_wr_i (wr_req_i),
    .gnt_rd_o (rd_gnt_o),
    .gnt_wr_o (wr_gnt_o)
  );

  assign grant = rd_gnt_o || wr_gnt_o;

  // Push path: the FIFO captures the winner's entry on the same edge.
  always_comb begin
    ap_read_o  = rd_gnt_o;
    ap_write_o = wr_gnt_o;
    ap_addr_o  = '0;
    ap_size_o  = '0;
    if (rd_gnt_o) begin
      ap_addr_o = rd_addr_i;
      ap_size_o = rd_size_i;
    end else if (wr_gnt_o) begin
      ap_addr_o = wr_addr_i;
      ap_size_o = wr_size_i;
    end
  end

  // Data-phase sequencer next-state logic.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        // A completion with no entry in flight is a protocol error.
        if (dp_done_i) begin
          err_d = 1'b1;
        end else if (ap_fifo_count_i != 3'd0) begin
          state_d = ACTIVE;
        end
      end
      ACTIVE: begin
        if (dp_done_i) begin
          state_d = POP;
        end
      end
      POP: begin
        if (dp_done_i) begin
          err_d = 1'b1;
        end
        // The popped entry is still counted this cycle, so more than one
        // entry, or a push landing now, means a new head is waiting.
        if ((ap_fifo_count_i > 3'd1) || grant) begin
          state_d = ACTIVE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    pop_d = (state_d == POP);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      err_q   <= 1'b0;
      pop_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      pop_q   <= pop_d;
    end
  end

  // A reset arriving while in POP must not also pop the FIFO it is clearing.
  assign fifo_rd_next_o = pop_q && !reset_i;
  assign busy_o         = !reset_i && ((state_q != IDLE) || (ap_fifo_count_i != 3'd0));
  assign err_o          = err_q;

endmodule

// File: tb/tb_ip_codma_ap_ctrl.sv
module tb_ip_codma_ap_ctrl;
  import ip_codma_fifo_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_i = 1'b1;
  logic        rd_req_i = 1'b0, wr_req_i = 1'b0;
  logic [31:0] rd_addr_i = '0, wr_addr_i = '0;
  logic [2:0]  rd_size_i = '0, wr_size_i = '0;
  logic        rd_gnt_o, wr_gnt_o;
  logic [2:0]  ap_fifo_count_i = '0;
  logic        ap_read_o, ap_write_o;
  logic [31:0] ap_addr_o;
  logic [2:0]  ap_size_o;
  logic        dp_done_i = 1'b0;
  logic        fifo_rd_next_o, busy_o, err_o;

  ip_codma_ap_ctrl dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .rd_req_i       (rd_req_i),
    .rd_addr_i      (rd_addr_i),
    .rd_size_i      (rd_size_i),
    .rd_gnt_o       (rd_gnt_o),
    .wr_req_i       (wr_req_i),
    .wr_addr_i      (wr_addr_i),
    .wr_size_i      (wr_size_i),
    .wr_gnt_o       (wr_gnt_o),
    .ap_fifo_count_i(ap_fifo_count_i),
    .ap_read_o      (ap_read_o),
    .ap_write_o     (ap_write_o),
    .ap_addr_o      (ap_addr_o),
    .ap_size_o      (ap_size_o),
    .dp_done_i      (dp_done_i),
    .fifo_rd_next_o (fifo_rd_next_o),
    .busy_o         (busy_o),
    .err_o          (err_o)
  );

  // Scoreboard queues
  typedef struct { int cyc; ap_entry_t e; } exp_push_t;
  typedef struct { int cyc; bit busy; bit err; } exp_stat_t;
  exp_push_t push_q[$];
  int        pop_q[$];
  exp_stat_t stat_q[$];

  // Plant: the AP FIFO contents as seen by the environment
  ap_entry_t env_fifo[$];

  // Reference model: what the head entry is doing
  typedef enum { M_WAIT, M_XFER, M_RELEASE } mphase_t;
  mphase_t m_ph = M_WAIT;
  bit      m_last_wr = 1'b1;
  bit      m_err = 1'b0;

  int n_tests = 0, n_fail = 0;
  int cyc = 0;
  bit saw_rg, saw_wg;

  // One clock cycle: apply inputs, predict, observe, advance plant and model.
  task automatic drive(input bit rst, input bit rq, input logic [31:0] ra, input logic [2:0] rs,
                       input bit wq, input logic [31:0] wa, input logic [2:0] ws, input bit dp);
    bit do_g, win_r, sg, sp;
    int cnt;
    ap_entry_t e, se;
    exp_push_t xp;
    exp_stat_t xs;
    reset_i = rst; rd_req_i = rq; rd_addr_i = ra; rd_size_i = rs;
    wr_req_i = wq; wr_addr_i = wa; wr_size_i = ws; dp_done_i = dp;
    cnt = env_fifo.size();
    ap_fifo_count_i = 3'(cnt);
    do_g  = !rst && (cnt < NO_OF_AF_BUFFERS) && (rq || wq);
    win_r = rq && (!wq || m_last_wr);
    if (do_g) begin
      e.read = win_r; e.write = !win_r;
      e.addr = win_r ? ra : wa; e.size = win_r ? rs : ws;
      xp.cyc = cyc; xp.e = e;
      push_q.push_back(xp);
    end
    if (!rst && m_ph == M_RELEASE) pop_q.push_back(cyc);
    xs.cyc = cyc; xs.busy = !rst && (m_ph != M_WAIT || cnt != 0); xs.err = m_err;
    stat_q.push_back(xs);
    if (!rst && m_ph == M_XFER) begin
      n_tests++;
      if (cnt == 0) begin
        n_fail++;
        $display("FAIL active_count cyc=%0d count=%0d required nonzero", cyc, cnt);
      end
    end
    @(negedge clk);
    sg = ap_read_o | ap_write_o;
    se.read = ap_read_o; se.write = ap_write_o; se.addr = ap_addr_o; se.size = ap_size_o;
    sp = fifo_rd_next_o;
    saw_rg = rd_gnt_o; saw_wg = wr_gnt_o;
    @(posedge clk);
    if (rst) env_fifo.delete();
    else begin
      if (sp && env_fifo.size() > 0) void'(env_fifo.pop_front());
      if (sg) env_fifo.push_back(se);
    end
    if (rst) begin
      m_ph = M_WAIT; m_last_wr = 1'b1; m_err = 1'b0;
    end else begin
      if (do_g) m_last_wr = !win_r;
      case (m_ph)
        M_WAIT:    if (dp) m_err = 1'b1; else if (cnt != 0) m_ph = M_XFER;
        M_XFER:    if (dp) m_ph = M_RELEASE;
        M_RELEASE: begin
          if (dp) m_err = 1'b1;
          m_ph = (cnt > 1 || do_g) ? M_XFER : M_WAIT;
        end
        default:   m_ph = M_WAIT;
      endcase
    end
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, m_ph == M_XFER);
  endtask

  // Monitor: compares whatever the DUT presents at each negedge
  always @(negedge clk) begin
    exp_stat_t xs;
    exp_push_t xp;
    int pc;
    if (stat_q.size() > 0) begin
      xs = stat_q.pop_front();
      n_tests++;
      if (busy_o !== xs.busy) begin
        n_fail++;
        $display("FAIL busy cyc=%0d got=%b exp=%b", xs.cyc, busy_o, xs.busy);
      end
      n_tests++;
      if (err_o !== xs.err) begin
        n_fail++;
        $display("FAIL err cyc=%0d got=%b exp=%b", xs.cyc, err_o, xs.err);
      end
      n_tests++;
      if (rd_gnt_o !== ap_read_o || wr_gnt_o !== ap_write_o) begin
        n_fail++;
        $display("FAIL gnt_vs_entry cyc=%0d gnt=%b%b entry=%b%b", xs.cyc, rd_gnt_o, wr_gnt_o, ap_read_o, ap_write_o);
      end
      if (ap_read_o | ap_write_o) begin
        n_tests++;
        if (push_q.size() == 0) begin
          n_fail++;
          $display("FAIL push_unexpected cyc=%0d got r=%b w=%b addr=%h exp none", xs.cyc, ap_read_o, ap_write_o, ap_addr_o);
        end else begin
          xp = push_q.pop_front();
          if (xp.cyc != xs.cyc || ap_read_o !== xp.e.read || ap_write_o !== xp.e.write ||
              ap_addr_o !== xp.e.addr || ap_size_o !== xp.e.size) begin
            n_fail++;
            $display("FAIL push cyc=%0d got r=%b w=%b addr=%h size=%0d exp cyc=%0d r=%b w=%b addr=%h size=%0d",
                     xs.cyc, ap_read_o, ap_write_o, ap_addr_o, ap_size_o,
                     xp.cyc, xp.e.read, xp.e.write, xp.e.addr, xp.e.size);
          end
        end
      end else begin
        n_tests++;
        if (ap_addr_o !== '0 || ap_size_o !== '0) begin
          n_fail++;
          $display("FAIL idle_entry cyc=%0d addr=%h size=%0d exp 0", xs.cyc, ap_addr_o, ap_size_o);
        end
      end
      if (fifo_rd_next_o) begin
        n_tests++;
        if (pop_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected cyc=%0d got=1 exp=0", xs.cyc);
        end else begin
          pc = pop_q.pop_front();
          if (pc != xs.cyc) begin
            n_fail++;
            $display("FAIL pop_cycle got=%0d exp=%0d", xs.cyc, pc);
          end
        end
      end
    end
  end

  initial begin
    bit rp, wp, rst, dp;
    logic [31:0] ra, wa;
    logic [2:0]  rs, ws;
    @(posedge clk); #1;

    // Reset with requests raised: nothing may be granted
    drive(1, 1, 32'h11, 1, 1, 32'h22, 2, 0);
    drive(1, 1, 32'h11, 1, 1, 32'h22, 2, 0);

    // Single read request, then one full data phase
    drive(0, 1, 32'h1000, 2, 0, 0, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);

    // Both requesters held: alternate until the FIFO is full, then pop once
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, 32'h2000, 1, 1, 32'h3000, 3, 0);
    drive(0, 1, 32'h2000, 1, 1, 32'h3000, 3, 1);
    for (int i = 0; i < 4; i++) drive(0, 1, 32'h2000, 1, 1, 32'h3000, 3, 0);
    drain(20);

    // Write grant landing in the POP cycle with one entry left
    drive(0, 1, 32'h4000, 0, 0, 0, 0, 0);
    idle(1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 32'h5000, 5, 0);
    idle(2);
    drain(10);

    // Randomized traffic
    rp = 0; wp = 0; ra = 0; wa = 0; rs = 0; ws = 0;
    for (int i = 0; i < 2000; i++) begin
      if (!rp && $urandom_range(0, 2) == 0) begin
        rp = 1; ra = $urandom; rs = 3'($urandom_range(0, 7));
      end
      if (!wp && $urandom_range(0, 2) == 0) begin
        wp = 1; wa = $urandom; ws = 3'($urandom_range(0, 7));
      end
      rst = ($urandom_range(0, 499) == 0);
      dp  = (m_ph == M_XFER) && ($urandom_range(0, 2) == 0);
      drive(rst, rp, ra, rs, wp, wa, ws, dp);
      if (saw_rg) rp = 0;
      if (saw_wg) wp = 0;
    end
    drain(20);

    // dp_done with nothing active: sticky error
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    idle(3);

    // Reset while a head entry is active, requests still raised
    drive(0, 1, 32'h6000, 4, 0, 0, 0, 0);
    idle(1);
    drive(1, 1, 32'h6100, 4, 1, 32'h7100, 6, 0);
    idle(3);

    repeat (3) @(negedge clk);
    n_tests++;
    if (push_q.size() != 0) begin
      n_fail++;
      $display("FAIL push_missing got=%0d outstanding exp=0", push_q.size());
    end
    n_tests++;
    if (pop_q.size() != 0) begin
      n_fail++;
      $display("FAIL pop_missing got=%0d outstanding exp=0", pop_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
